spi_mem_loader: RTL and testbench

Parametrised SPI slave front-end that loads the display frame memory over SPI. It supersedes the fixed mode-0, byte-wide receive path inside the display-controller top. It oversamples SCLK/SS/MOSI in the system clock domain and supports all four SPI modes, a configurable word width and an optional address-header word. Each completed word becomes a single-cycle write strobe to the frame memory with an auto-incrementing, wrapping address. MISO echoes the previous word for host-side link checking.

---
 rtl/spi_mem_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_mem_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_loader.sv
// SPI slave front-end that loads the display frame memory.
// Oversamples SCLK/SS/MOSI in the clk domain, supports all four SPI modes,
// a configurable word width and an optional address-header word. Each
// completed data word becomes a one-cycle memory write at an auto-incrementing,
// wrapping address; MISO echoes the previously received word.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   spi_sclk     SPI clock (asynchronous)
//   spi_ss       SPI slave select, active low (asynchronous)
//   spi_mosi     SPI data in, MSB first
//   spi_miso     SPI data out, MSB first; 0 while SS is high
//   mem_we       one-cycle write strobe
//   mem_addr     write address, valid with mem_we
//   mem_wdata    write data, valid with mem_we
//   frame_done   one-cycle pulse when SS ends an active frame
//   word_count   data words written in the last frame (saturating)
//   err_partial  sticky: last frame ended mid-word; cleared at next frame start
module spi_mem_loader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          ADDR_HEADER = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_ss,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  frame_done,
  output logic [15:0]           word_count,
  output logic                  err_partial
);

  localparam int unsigned      CNT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_WIDTH - 1);
  localparam bit               SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    HEADER,
    DATA
  } state_t;

  state_t state, state_nxt;

  // Synchronisers; the third SCLK stage is the edge-detect reference
  logic [2:0] sclk_q;
  logic [1:0] ss_q;
  logic [1:0] mosi_q;

  logic sclk_s2, sclk_s3, ss_s, mosi_s;
  logic rise_c, fall_c, sample_c, shift_c;

  // Datapath state
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] miso_sr;
  logic [DATA_WIDTH-1:0] echo_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] word_c;

  // FSM decisions
  logic active_c, last_c, start_c, hdr_load_c, wr_c, end_c, err_c;

  // Synchroniser chain; SCLK resets to its idle level so reset release
  // cannot fake an edge, SS resets low so WAIT_IDLE needs a real SS high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= {3{CPOL}};
      ss_q   <= 2'b00;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      ss_q   <= {ss_q[0], spi_ss};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sclk_s2  = sclk_q[1];
  assign sclk_s3  = sclk_q[2];
  assign ss_s     = ss_q[1];
  assign mosi_s   = mosi_q[1];
  assign rise_c   = sclk_s2 & ~sclk_s3;
  assign fall_c   = ~sclk_s2 & sclk_s3;
  assign sample_c = SAMPLE_RISE ? rise_c : fall_c;
  assign shift_c  = SAMPLE_RISE ? fall_c : rise_c;

  assign word_c   = {shift_q[DATA_WIDTH-2:0], mosi_s};
  assign active_c = (state == HEADER) || (state == DATA);
  assign last_c   = sample_c && (bit_cnt == LAST_BIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; an SS rise in the same cycle as the last
  // sample still completes the word before the frame closes
  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    hdr_load_c = 1'b0;
    wr_c       = 1'b0;
    end_c      = 1'b0;
    err_c      = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (ss_s) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (!ss_s) begin
          start_c   = 1'b1;
          state_nxt = ADDR_HEADER ? HEADER : DATA;
        end
      end
      HEADER: begin
        if (last_c) begin
          hdr_load_c = 1'b1;
          state_nxt  = DATA;
        end
        if (ss_s) begin
          end_c     = 1'b1;
          err_c     = !last_c && ((bit_cnt != '0) || sample_c);
          state_nxt = IDLE;
        end
      end
      DATA: begin
        wr_c = last_c;
        if (ss_s) begin
          end_c     = 1'b1;
          err_c     = !last_c && ((bit_cnt != '0) || sample_c);
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = WAIT_IDLE;
      end
    endcase
  end

  // Receive/transmit datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      miso_sr     <= '0;
      echo_q      <= '0;
      addr_q      <= '0;
      bit_cnt     <= '0;
      spi_miso    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      frame_done  <= 1'b0;
      word_count  <= '0;
      err_partial <= 1'b0;
    end else begin
      mem_we     <= wr_c;
      frame_done <= end_c;
      if (start_c) begin
        err_partial <= 1'b0;
        bit_cnt     <= '0;
        word_count  <= '0;
        addr_q      <= '0;
        shift_q     <= '0;
        miso_sr     <= echo_q;
        // CPHA=0 hosts sample the first bit before any SCLK edge
        if (CPHA) begin
          spi_miso <= 1'b0;
        end else begin
          spi_miso <= echo_q[DATA_WIDTH-1];
        end
      end else if (active_c) begin
        if (sample_c) begin
          shift_q <= word_c;
          bit_cnt <= last_c ? '0 : bit_cnt + CNT_W'(1);
        end
        if (hdr_load_c) begin
          addr_q <= ADDR_WIDTH'(word_c);
        end
        if (wr_c) begin
          mem_addr  <= addr_q;
          mem_wdata <= word_c;
          addr_q    <= addr_q + ADDR_WIDTH'(1);
          echo_q    <= word_c;
          miso_sr   <= word_c;
          if (word_count != 16'hFFFF) begin
            word_count <= word_count + 16'd1;
          end
          if (!CPHA) begin
            spi_miso <= word_c[DATA_WIDTH-1];
          end
        end else if (shift_c && !ss_s) begin
          if (CPHA) begin
            // Leading edge presents the next bit
            spi_miso <= miso_sr[DATA_WIDTH-1];
            miso_sr  <= {miso_sr[DATA_WIDTH-2:0], 1'b0};
          end else if (bit_cnt != '0) begin
            // Trailing edge after a word's last bit must keep the reloaded MSB
            spi_miso <= miso_sr[DATA_WIDTH-2];
            miso_sr  <= {miso_sr[DATA_WIDTH-2:0], 1'b0};
          end
        end
        if (end_c) begin
          err_partial <= err_c;
          spi_miso    <= 1'b0;
        end
      end else begin
        spi_miso <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Bench for spi_mem_loader: five instances (modes 0..3, plus a header-mode
// instance with a 4-bit address) share SS/MOSI and see the same frames.
// A frame-level model derives the expected writes, word counts and error
// flags per instance; a compare process checks outputs on every clk.
module tb_spi_mem_loader;

  localparam int NDUT = 5;
  localparam int HP   = 60;
  localparam int DP   = 30;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sck  = 1'b0;
  logic sckn;
  logic ss   = 1'b1;
  logic mosi = 1'b0;

  logic       miso_a [NDUT];
  logic       we_a   [NDUT];
  logic       fd_a   [NDUT];
  logic       err_a  [NDUT];
  logic [9:0] addr_a [NDUT];
  logic [7:0] data_a [NDUT];
  logic [15:0] wc_a  [NDUT];
  logic [3:0] addr_h;

  assign sckn      = ~sck;
  assign addr_a[4] = {6'd0, addr_h};

  always #5 clk = ~clk;

  spi_mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CPOL(1'b0), .CPHA(1'b0), .ADDR_HEADER(1'b0)) u_m0 (
    .clk(clk), .rst(rst), .spi_sclk(sck), .spi_ss(ss), .spi_mosi(mosi), .spi_miso(miso_a[0]),
    .mem_we(we_a[0]), .mem_addr(addr_a[0]), .mem_wdata(data_a[0]), .frame_done(fd_a[0]),
    .word_count(wc_a[0]), .err_partial(err_a[0]));
  spi_mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CPOL(1'b0), .CPHA(1'b1), .ADDR_HEADER(1'b0)) u_m1 (
    .clk(clk), .rst(rst), .spi_sclk(sck), .spi_ss(ss), .spi_mosi(mosi), .spi_miso(miso_a[1]),
    .mem_we(we_a[1]), .mem_addr(addr_a[1]), .mem_wdata(data_a[1]), .frame_done(fd_a[1]),
    .word_count(wc_a[1]), .err_partial(err_a[1]));
  spi_mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CPOL(1'b1), .CPHA(1'b0), .ADDR_HEADER(1'b0)) u_m2 (
    .clk(clk), .rst(rst), .spi_sclk(sckn), .spi_ss(ss), .spi_mosi(mosi), .spi_miso(miso_a[2]),
    .mem_we(we_a[2]), .mem_addr(addr_a[2]), .mem_wdata(data_a[2]), .frame_done(fd_a[2]),
    .word_count(wc_a[2]), .err_partial(err_a[2]));
  spi_mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .CPOL(1'b1), .CPHA(1'b1), .ADDR_HEADER(1'b0)) u_m3 (
    .clk(clk), .rst(rst), .spi_sclk(sckn), .spi_ss(ss), .spi_mosi(mosi), .spi_miso(miso_a[3]),
    .mem_we(we_a[3]), .mem_addr(addr_a[3]), .mem_wdata(data_a[3]), .frame_done(fd_a[3]),
    .word_count(wc_a[3]), .err_partial(err_a[3]));
  spi_mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CPOL(1'b0), .CPHA(1'b0), .ADDR_HEADER(1'b1)) u_h (
    .clk(clk), .rst(rst), .spi_sclk(sck), .spi_ss(ss), .spi_mosi(mosi), .spi_miso(miso_a[4]),
    .mem_we(we_a[4]), .mem_addr(addr_h), .mem_wdata(data_a[4]), .frame_done(fd_a[4]),
    .word_count(wc_a[4]), .err_partial(err_a[4]));

  // Per-instance configuration as seen by the model
  int cpha_p [NDUT] = '{0, 1, 0, 1, 0};
  int hdr_p  [NDUT] = '{0, 0, 0, 0, 1};
  int aw_p   [NDUT] = '{10, 10, 10, 10, 4};

  logic [17:0] expq    [NDUT][$];
  logic [15:0] exp_wc  [NDUT];
  logic        exp_err [NDUT];
  int          fd_cnt  [NDUT];
  logic [7:0]  echo_m  [NDUT];
  logic [17:0] last_wr [NDUT];
  logic [17:0] cmp_e;

  logic [7:0] fq[$];
  logic [7:0] miso_start;
  bit         chk_miso = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic fbit(input int j);
    logic [7:0] b;
    b = fq[j / 8];
    return b[7 - (j % 8)];
  endfunction

  // Frame-level model: split the received bits into whole words, first word
  // is the address when headers are on, every other word is a write
  task automatic model_frame(input int nbits, input bit at_lead);
    for (int i = 0; i < NDUT; i++) begin
      int nb;
      int nw;
      int wc;
      logic [9:0] a;
      logic [9:0] mask;
      logic [7:0] w;
      nb   = nbits - ((at_lead && (cpha_p[i] != 0)) ? 1 : 0);
      nw   = nb / 8;
      mask = 10'((1 << aw_p[i]) - 1);
      a    = '0;
      wc   = 0;
      for (int k = 0; k < nw; k++) begin
        w = fq[k];
        if ((hdr_p[i] != 0) && (k == 0)) begin
          a = {2'b00, w} & mask;
        end else begin
          expq[i].push_back({a, w});
          a = (a + 10'd1) & mask;
          wc++;
          echo_m[i] = w;
        end
      end
      exp_wc[i]  = 16'(wc);
      exp_err[i] = (nb % 8) != 0;
      fd_cnt[i]  = 0;
    end
  endtask

  // Host bit timing: MOSI set, leading edge HP later, trailing edge HP later,
  // MOSI changes DP after the trailing edge (valid for both CPHA settings)
  task automatic drive_bits(input int nb, input bit at_lead);
    for (int j = 0; j < nb; j++) begin
      logic [7:0] w;
      mosi = fbit(j);
      #(HP);
      if (chk_miso) begin
        w = (j < 8) ? miso_start : fq[j / 8 - 1];
        chk("miso", 0, 32'(miso_a[0]), 32'(w[7 - (j % 8)]));
      end
      if (at_lead && (j == nb - 1)) begin
        sck = 1'b1;
        ss  = 1'b1;
        #(HP);
        sck = 1'b0;
      end else begin
        sck = 1'b1;
        #(HP);
        sck = 1'b0;
        #(DP);
      end
    end
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_ctrl", i, 32'({we_a[i], fd_a[i], err_a[i], miso_a[i]}), 32'd0);
      chk("reset_word_count", i, 32'(wc_a[i]), 32'd0);
      chk("reset_addr_data", i, 32'({addr_a[i], data_a[i]}), 32'd0);
    end
  endtask

  task automatic post_checks(input int exp_fd);
    for (int i = 0; i < NDUT; i++) begin
      chk("pending_writes", i, 32'(expq[i].size()), 32'd0);
      chk("frame_done_count", i, 32'(fd_cnt[i]), 32'(exp_fd));
      if (exp_fd != 0) begin
        chk("word_count_hold", i, 32'(wc_a[i]), 32'(exp_wc[i]));
        chk("err_partial", i, 32'(err_a[i]), 32'(exp_err[i]));
      end
    end
    chk("miso_idle", 0, 32'(miso_a[0]), 32'd0);
  endtask

  task automatic do_frame(input int nbits, input bit at_lead);
    miso_start = echo_m[0];
    model_frame(nbits, at_lead);
    chk_miso = 1'b1;
    ss = 1'b0;
    #(HP);
    for (int i = 0; i < NDUT; i++) begin
      chk("err_clear_at_start", i, 32'(err_a[i]), 32'd0);
    end
    drive_bits(nbits, at_lead);
    if (!at_lead) begin
      #(HP);
      ss = 1'b1;
    end
    #(300);
    chk_miso = 1'b0;
    post_checks(1);
  endtask

  // Every-cycle compare of writes and frame-end status
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (we_a[i] === 1'b1) begin
        if (expq[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write dut%0d: got addr %0h data %0h expected no write",
                   i, addr_a[i], data_a[i]);
        end else begin
          cmp_e = expq[i].pop_front();
          chk("write", i, 32'({addr_a[i], data_a[i]}), 32'(cmp_e));
          last_wr[i] = {addr_a[i], data_a[i]};
        end
      end
      if (fd_a[i] === 1'b1) begin
        fd_cnt[i]++;
        chk("fd_word_count", i, 32'(wc_a[i]), 32'(exp_wc[i]));
        chk("fd_err_partial", i, 32'(err_a[i]), 32'(exp_err[i]));
      end
    end
  end

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      echo_m[i]  = '0;
      last_wr[i] = '0;
      fd_cnt[i]  = 0;
      exp_wc[i]  = '0;
      exp_err[i] = 1'b0;
    end
    #(23);
    check_reset_state();
    #(20);
    rst = 1'b0;
    #(100);

    // Basic frame, all modes
    fq = '{8'hF0, 8'hFF, 8'h00, 8'hFF};
    do_frame(32, 1'b0);
    chk("lit_m0_word_count", 0, 32'(wc_a[0]), 32'd4);
    chk("lit_m3_last_write", 3, 32'(last_wr[3]), 32'({10'd3, 8'hFF}));

    // Echo of previous frame's last word
    fq = '{8'hA5, 8'h5A};
    do_frame(16, 1'b0);
    chk("lit_m1_last_write", 1, 32'(last_wr[1]), 32'({10'd1, 8'h5A}));

    // Header E then wrap on the 4-bit address instance
    fq = '{8'h0E, 8'h11, 8'h22, 8'h33};
    do_frame(32, 1'b0);
    chk("lit_h_last_write", 4, 32'(last_wr[4]), 32'({10'd0, 8'h33}));
    chk("lit_h_word_count", 4, 32'(wc_a[4]), 32'd3);

    // 12-bit partial frame
    fq = '{8'h12, 8'h34};
    do_frame(12, 1'b0);
    chk("lit_m0_err_partial", 0, 32'(err_a[0]), 32'd1);
    chk("lit_m0_partial_wc", 0, 32'(wc_a[0]), 32'd1);

    // SS rise coincident with the last leading edge
    fq = '{8'h9A, 8'hBC};
    do_frame(16, 1'b1);
    chk("lit_m0_coincident_err", 0, 32'(err_a[0]), 32'd0);
    chk("lit_m0_coincident_wc", 0, 32'(wc_a[0]), 32'd2);
    chk("lit_m1_coincident_err", 1, 32'(err_a[1]), 32'd1);

    // Header-only frame on the header instance
    fq = '{8'h07};
    do_frame(8, 1'b0);
    chk("lit_h_header_only_wc", 4, 32'(wc_a[4]), 32'd0);
    chk("lit_m0_single_write", 0, 32'(last_wr[0]), 32'({10'd0, 8'h07}));

    // Reset in the middle of a word with SS held low
    for (int i = 0; i < NDUT; i++) begin
      fd_cnt[i] = 0;
    end
    fq = '{8'hF0};
    ss = 1'b0;
    #(HP);
    drive_bits(4, 1'b0);
    rst = 1'b1;
    #(35);
    check_reset_state();
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      echo_m[i] = '0;
      exp_wc[i] = '0;
      exp_err[i] = 1'b0;
    end
    fq = '{8'hAA};
    drive_bits(8, 1'b0);
    #(HP);
    ss = 1'b1;
    #(300);
    post_checks(0);

    // First frame after reset recovery
    fq = '{8'h3C};
    do_frame(8, 1'b0);
    chk("lit_m0_after_reset", 0, 32'(last_wr[0]), 32'({10'd0, 8'h3C}));

    #(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
